// File: rtl/ahb_apb_pkg.sv
// Shared AHB-to-APB bridge definitions: transfer encodings,
// checker states and the default APB address window.
package ahb_apb_pkg;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic [2:0] HS_BYTE = 3'd0;
  localparam logic [2:0] HS_HALF = 3'd1;
  localparam logic [2:0] HS_WORD = 3'd2;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h8000_0000;
  localparam logic [31:0] DEF_LIMIT_ADDR = 32'h8C00_0000;

  typedef enum logic [1:0] {
    CK_IDLE   = 2'd0,
    CK_ACTIVE = 2'd1,
    CK_BUSY   = 2'd2
  } ck_state_e;

  function automatic logic [31:0] size_bytes(
    input logic [2:0] sz
  );
    return 32'd1 << sz;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] a_lo,
    input logic [2:0] sz
  );
    logic m;
    m = 1'b0;
    case (sz)
      HS_HALF: m = a_lo[0];
      HS_WORD: m = |a_lo;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_slave_if_prot_chk.sv
// AHB htrans sequencing and burst address checker.
// Flags violations combinationally and as a registered pulse.
module ahb_prot_chk
  import ahb_apb_pkg::*;
(
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic        sel,
  output logic        err_now,
  output logic        prot_err
);

  ck_state_e   state_q, state_d;
  logic [31:0] last_addr_q, last_addr_d;
  logic [2:0]  last_size_q, last_size_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        prot_err_q, prot_err_d;

  logic        is_idle, is_busy, is_nseq, is_seq;
  logic        from_idle;
  logic [31:0] exp_addr;
  logic        v_idle, v_addr, v_size, v_hsz, v_align;

  assign is_idle   = (htrans == HT_IDLE);
  assign is_busy   = (htrans == HT_BUSY);
  assign is_nseq   = (htrans == HT_NONSEQ);
  assign is_seq    = (htrans == HT_SEQ);
  assign from_idle = (state_q == CK_IDLE);

  assign exp_addr = last_addr_q + size_bytes(last_size_q);

  assign v_idle  = (is_seq || is_busy) && from_idle;
  assign v_addr  = is_seq && (haddr != exp_addr);
  assign v_size  = is_seq && (hsize != last_size_q);
  assign v_hsz   = (hsize > HS_WORD);
  assign v_align = misaligned(haddr[1:0], hsize);

  // Out-of-window beats still drive the checker but never report.
  assign err_now = hreadyin && !is_idle && sel &&
                   (v_idle || v_addr || v_size ||
                    v_hsz || v_align);

  always_comb begin
    state_d     = state_q;
    last_addr_d = last_addr_q;
    last_size_d = last_size_q;
    beat_cnt_d  = beat_cnt_q;
    prot_err_d  = err_now;
    if (hreadyin) begin
      unique case (1'b1)
        is_idle: state_d = CK_IDLE;
        is_nseq: state_d = CK_ACTIVE;
        is_seq:  state_d = from_idle ? CK_IDLE
                                     : CK_ACTIVE;
        is_busy: state_d = from_idle ? CK_IDLE
                                     : CK_BUSY;
        default: state_d = state_q;
      endcase
      if (htrans[1]) begin
        last_addr_d = haddr;
        last_size_d = hsize;
      end
      if (is_nseq) begin
        beat_cnt_d = 4'd0;
      end else if (is_seq && beat_cnt_q != 4'hF) begin
        beat_cnt_d = beat_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q     <= CK_IDLE;
      last_addr_q <= '0;
      last_size_q <= '0;
      beat_cnt_q  <= '0;
      prot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_addr_q <= last_addr_d;
      last_size_q <= last_size_d;
      beat_cnt_q  <= beat_cnt_d;
      prot_err_q  <= prot_err_d;
    end
  end

  assign prot_err = prot_err_q;

endmodule

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: window decode,
// address/data pipeline and protocol checking.
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [31:0] LIMIT_ADDR = DEF_LIMIT_ADDR
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        valid,
  output logic        temp_selx,
  output logic [31:0] haddr_1,
  output logic [31:0] haddr_2,
  output logic [31:0] hwdata_1,
  output logic [31:0] hwdata_2,
  output logic        hwrite_reg,
  output logic        hwrite_reg_1,
  output logic        prot_err
);

  logic [31:0] haddr_1_q, haddr_1_d;
  logic [31:0] haddr_2_q, haddr_2_d;
  logic [31:0] hwdata_1_q, hwdata_1_d;
  logic [31:0] hwdata_2_q, hwdata_2_d;
  logic        hwrite_reg_q, hwrite_reg_d;
  logic        hwrite_reg_1_q, hwrite_reg_1_d;
  logic        err_now;

  assign temp_selx = (haddr >= BASE_ADDR) &&
                     (haddr < LIMIT_ADDR);

  assign valid = hreadyin && htrans[1] &&
                 temp_selx && !err_now;

  ahb_prot_chk u_chk (
    .hclk     (hclk),
    .hreset   (hreset),
    .hreadyin (hreadyin),
    .htrans   (htrans),
    .hsize    (hsize),
    .haddr    (haddr),
    .sel      (temp_selx),
    .err_now  (err_now),
    .prot_err (prot_err)
  );

  // Free-running shift; a stalled master holds its bus steady.
  always_comb begin
    haddr_1_d      = haddr;
    haddr_2_d      = haddr_1_q;
    hwdata_1_d     = hwdata;
    hwdata_2_d     = hwdata_1_q;
    hwrite_reg_d   = hwrite;
    hwrite_reg_1_d = hwrite_reg_q;
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      haddr_1_q      <= '0;
      haddr_2_q      <= '0;
      hwdata_1_q     <= '0;
      hwdata_2_q     <= '0;
      hwrite_reg_q   <= 1'b0;
      hwrite_reg_1_q <= 1'b0;
    end else begin
      haddr_1_q      <= haddr_1_d;
      haddr_2_q      <= haddr_2_d;
      hwdata_1_q     <= hwdata_1_d;
      hwdata_2_q     <= hwdata_2_d;
      hwrite_reg_q   <= hwrite_reg_d;
      hwrite_reg_1_q <= hwrite_reg_1_d;
    end
  end

  assign haddr_1      = haddr_1_q;
  assign haddr_2      = haddr_2_q;
  assign hwdata_1     = hwdata_1_q;
  assign hwdata_2     = hwdata_2_q;
  assign hwrite_reg   = hwrite_reg_q;
  assign hwrite_reg_1 = hwrite_reg_1_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: per-feature tasks with
// a prot_err scoreboard queue filled as beats are driven.
module tb_ahb_slave_if;
  import ahb_apb_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic        hreadyin;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        valid;
  logic        temp_selx;
  logic [31:0] haddr_1, haddr_2;
  logic [31:0] hwdata_1, hwdata_2;
  logic        hwrite_reg, hwrite_reg_1;
  logic        prot_err;

  int n_chk = 0;
  int n_fail = 0;
  bit sb[$];
  bit e;

  always #5 hclk = ~hclk;

  ahb_slave_if dut (
    .hclk         (hclk),
    .hreset       (hreset),
    .htrans       (htrans),
    .hsize        (hsize),
    .hwrite       (hwrite),
    .hreadyin     (hreadyin),
    .haddr        (haddr),
    .hwdata       (hwdata),
    .valid        (valid),
    .temp_selx    (temp_selx),
    .haddr_1      (haddr_1),
    .haddr_2      (haddr_2),
    .hwdata_1     (hwdata_1),
    .hwdata_2     (hwdata_2),
    .hwrite_reg   (hwrite_reg),
    .hwrite_reg_1 (hwrite_reg_1),
    .prot_err     (prot_err)
  );

  task automatic drive(input logic [1:0] tr,
                       input logic [2:0] sz,
                       input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic rdy);
    htrans = tr; hsize = sz; hwrite = wr;
    haddr = a; hwdata = wd; hreadyin = rdy;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b0;
    drive(HT_NONSEQ, HS_WORD, 1'b1, 32'h8000_0000,
          32'hDEAD_BEEF, 1'b1);
    next_cycle();
    next_cycle();
    n_chk++;
    if ({haddr_1, haddr_2, hwdata_1, hwdata_2} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_pipe: got %h %h %h %h expected zeros",
               haddr_1, haddr_2, hwdata_1, hwdata_2);
    end
    n_chk++;
    if ({hwrite_reg, hwrite_reg_1, prot_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b%b%b expected 000",
               hwrite_reg, hwrite_reg_1, prot_err);
    end
    n_chk++;
    if (temp_selx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_selx: got %b expected 1", temp_selx);
    end
    hreset = 1'b1;
    sb.push_back(1'b0);
    next_cycle();
    n_chk++;
    if (haddr_1 !== 32'h8000_0000 || hwrite_reg !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: haddr_1=%h hwrite_reg=%b expected 80000000 1",
               haddr_1, hwrite_reg);
    end
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e) begin
      n_fail++;
      $display("FAIL reset_err: got %b expected %b", prot_err, e);
    end
    drive(HT_IDLE, HS_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
    next_cycle();
  endtask

  task automatic test_single_write();
    drive(HT_NONSEQ, HS_WORD, 1'b1, 32'h8000_0010, 32'h0, 1'b1);
    n_chk++;
    if (valid !== 1'b1 || temp_selx !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_addr: valid=%b selx=%b expected 1 1",
               valid, temp_selx);
    end
    sb.push_back(1'b0);
    next_cycle();
    n_chk++;
    if (hwrite_reg !== 1'b1 || haddr_1 !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL wr_pipe: hwrite_reg=%b haddr_1=%h expected 1 80000010",
               hwrite_reg, haddr_1);
    end
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e) begin
      n_fail++;
      $display("FAIL wr_err: got %b expected %b", prot_err, e);
    end
    drive(HT_IDLE, HS_WORD, 1'b0, 32'h0, 32'hA5A5_0001, 1'b1);
    next_cycle();
    n_chk++;
    if (hwdata_1 !== 32'hA5A5_0001 || haddr_2 !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL wr_data: hwdata_1=%h haddr_2=%h expected a5a50001 80000010",
               hwdata_1, haddr_2);
    end
    drive(HT_IDLE, HS_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
    next_cycle();
    n_chk++;
    if (hwdata_2 !== 32'hA5A5_0001 || hwdata_1 !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_data2: hwdata_2=%h hwdata_1=%h expected a5a50001 0",
               hwdata_2, hwdata_1);
    end
  endtask

  task automatic test_burst_busy();
    logic [1:0]  tr[4];
    logic [31:0] ad[4];
    logic        ev[4];
    tr = '{HT_NONSEQ, HT_SEQ, HT_BUSY, HT_SEQ};
    ad = '{32'h8000_0000, 32'h8000_0004,
           32'h8000_0008, 32'h8000_0008};
    ev = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(tr[i], HS_WORD, 1'b0, ad[i], 32'h0, 1'b1);
      n_chk++;
      if (valid !== ev[i]) begin
        n_fail++;
        $display("FAIL burst_valid[%0d]: got %b expected %b",
                 i, valid, ev[i]);
      end
      sb.push_back(1'b0);
      next_cycle();
      e = sb.pop_front();
      n_chk++;
      if (prot_err !== e) begin
        n_fail++;
        $display("FAIL burst_err[%0d]: got %b expected %b",
                 i, prot_err, e);
      end
    end
    drive(HT_IDLE, HS_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
    next_cycle();
  endtask

  task automatic test_bad_incr();
    drive(HT_NONSEQ, HS_WORD, 1'b0, 32'h8000_0000, 32'h0, 1'b1);
    sb.push_back(1'b0);
    next_cycle();
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e) begin
      n_fail++;
      $display("FAIL incr_err0: got %b expected %b", prot_err, e);
    end
    drive(HT_SEQ, HS_WORD, 1'b0, 32'h8000_000C, 32'h0, 1'b1);
    n_chk++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL incr_valid: got %b expected 0", valid);
    end
    sb.push_back(1'b1);
    next_cycle();
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e) begin
      n_fail++;
      $display("FAIL incr_err1: got %b expected %b", prot_err, e);
    end
    drive(HT_IDLE, HS_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
    sb.push_back(1'b0);
    next_cycle();
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e) begin
      n_fail++;
      $display("FAIL incr_err2: got %b expected %b", prot_err, e);
    end
  endtask

  task automatic test_misalign_window();
    logic [31:0] ad[4];
    logic [2:0]  sz[4];
    logic        es[4];
    logic        ee[4];
    ad = '{32'h8000_0001, 32'h0, 32'h8C00_0000, 32'h0};
    sz = '{HS_HALF, HS_WORD, HS_WORD, HS_WORD};
    es = '{1'b1, 1'b0, 1'b0, 1'b0};
    ee = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive((i % 2 == 0) ? HT_NONSEQ : HT_IDLE, sz[i], 1'b0,
            ad[i], 32'h0, 1'b1);
      n_chk++;
      if (valid !== 1'b0 || temp_selx !== es[i]) begin
        n_fail++;
        $display("FAIL mw_comb[%0d]: valid=%b selx=%b expected 0 %b",
                 i, valid, temp_selx, es[i]);
      end
      sb.push_back(ee[i]);
      next_cycle();
      e = sb.pop_front();
      n_chk++;
      if (prot_err !== e) begin
        n_fail++;
        $display("FAIL mw_err[%0d]: got %b expected %b",
                 i, prot_err, e);
      end
    end
  endtask

  task automatic test_stall();
    drive(HT_NONSEQ, HS_WORD, 1'b0, 32'h8000_0000, 32'h0, 1'b1);
    sb.push_back(1'b0);
    next_cycle();
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e) begin
      n_fail++;
      $display("FAIL stall_err0: got %b expected %b", prot_err, e);
    end
    for (int i = 0; i < 3; i++) begin
      drive(HT_SEQ, HS_WORD, 1'b0, 32'h8000_0004, 32'h0, 1'b0);
      n_chk++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_valid[%0d]: got %b expected 0", i, valid);
      end
      sb.push_back(1'b0);
      next_cycle();
      e = sb.pop_front();
      n_chk++;
      if (prot_err !== e || dut.u_chk.beat_cnt_q !== 4'd0 ||
          dut.u_chk.state_q !== CK_ACTIVE) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: err=%b cnt=%0d st=%0d expected %b 0 1",
                 i, prot_err, dut.u_chk.beat_cnt_q,
                 dut.u_chk.state_q, e);
      end
    end
    drive(HT_SEQ, HS_WORD, 1'b0, 32'h8000_0004, 32'h0, 1'b1);
    n_chk++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got %b expected 1", valid);
    end
    sb.push_back(1'b0);
    next_cycle();
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e || dut.u_chk.beat_cnt_q !== 4'd1) begin
      n_fail++;
      $display("FAIL stall_after: err=%b cnt=%0d expected %b 1",
               prot_err, dut.u_chk.beat_cnt_q, e);
    end
    drive(HT_IDLE, HS_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
    next_cycle();
  endtask

  task automatic test_wrap();
    drive(HT_NONSEQ, HS_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1);
    sb.push_back(1'b0);
    next_cycle();
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e) begin
      n_fail++;
      $display("FAIL wrap_err0: got %b expected %b", prot_err, e);
    end
    drive(HT_SEQ, HS_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
    n_chk++;
    if (valid !== 1'b0 || temp_selx !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_comb: valid=%b selx=%b expected 0 0",
               valid, temp_selx);
    end
    sb.push_back(1'b0);
    next_cycle();
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e) begin
      n_fail++;
      $display("FAIL wrap_err1: got %b expected %b", prot_err, e);
    end
    drive(HT_IDLE, HS_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    drive(HT_NONSEQ, HS_WORD, 1'b0, 32'h8000_0000, 32'h0, 1'b1);
    n_chk++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmb_nseq: got %b expected 1", valid);
    end
    next_cycle();
    hreset = 1'b0;
    drive(HT_SEQ, HS_WORD, 1'b0, 32'h8000_0004, 32'h0, 1'b1);
    n_chk++;
    if (prot_err !== 1'b0 || haddr_1 !== 32'h0) begin
      n_fail++;
      $display("FAIL rmb_async: err=%b haddr_1=%h expected 0 0",
               prot_err, haddr_1);
    end
    hreset = 1'b1;
    #1;
    n_chk++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmb_valid: got %b expected 0", valid);
    end
    sb.push_back(1'b1);
    next_cycle();
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e) begin
      n_fail++;
      $display("FAIL rmb_err: got %b expected %b", prot_err, e);
    end
    drive(HT_IDLE, HS_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
    sb.push_back(1'b0);
    next_cycle();
    e = sb.pop_front();
    n_chk++;
    if (prot_err !== e) begin
      n_fail++;
      $display("FAIL rmb_err_end: got %b expected %b", prot_err, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    hreset = 1'b0;
    htrans = HT_IDLE; hsize = HS_WORD; hwrite = 1'b0;
    hreadyin = 1'b1; haddr = '0; hwdata = '0;
    @(posedge hclk);
    #1;
    test_reset();
    test_single_write();
    test_burst_busy();
    test_bad_incr();
    test_misalign_window();
    test_stall();
    test_wrap();
    test_reset_mid_burst();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
